// File: rtl/nios_accelerometer_capture_pkg.sv
// Shared register-map constants for the FIR output capture slave.
package nios_accelerometer_capture_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_CONTROL  = 2'd3;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_LEVEL_LSB = 8;

    localparam int CTRL_FLUSH = 0;

    // Assemble the STATUS word; every bit not named here reads 0.
    function automatic logic [31:0] pack_status(input logic       not_empty,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic [7:0] level);
        logic [31:0] word;
        word                     = '0;
        word[ST_NOT_EMPTY]       = not_empty;
        word[ST_FULL]            = full;
        word[ST_OVF]             = ovf;
        word[ST_LEVEL_LSB +: 8]  = level;
        return word;
    endfunction

endpackage

// File: rtl/nios_accelerometer_sample_fifo.sv
// Small synchronous FIFO holding filtered samples until the CPU reads them.
// Push is ignored when full, pop is ignored when empty, and flush overrides both.
module nios_accelerometer_sample_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign level = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next pointer/count state; flush clears everything and discards a same-cycle push.
    always_comb begin
        push_ok  = push && !full && !flush;
        pop_ok   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are never reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/nios_accelerometer_fir_out_capture.sv
// Avalon-MM readback slave for filtered accelerometer samples: stream in,
// FIFO buffer, and DATA/STATUS/IRQ_MASK/CONTROL registers for the Nios II.
module nios_accelerometer_fir_out_capture
    import nios_accelerometer_capture_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready
);

    localparam int AW = $clog2(DEPTH);

    logic              rd_strobe;
    logic              wr_strobe;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [DATA_W-1:0] fifo_head;
    logic [AW:0]       fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        level_byte;
    logic              ovf_set;
    logic              ovf_clear;
    logic              ovf_q, ovf_d;
    logic              irq_mask_q, irq_mask_d;
    logic              irq_q, irq_d;
    logic              unused_writedata;

    assign rd_strobe  = chipselect && !read_n;
    assign wr_strobe  = chipselect && !write_n;
    assign fifo_pop   = rd_strobe && (address == ADDR_DATA);
    assign fifo_flush = wr_strobe && (address == ADDR_CONTROL) && writedata[CTRL_FLUSH];
    assign in_ready   = !fifo_full;
    assign irq        = irq_q;
    assign level_byte = 8'(fifo_level);

    assign unused_writedata = ^{writedata[31:3], writedata[1]};

    nios_accelerometer_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Register next-state: a dropped sample beats a same-cycle clear, a flush suppresses the drop.
    always_comb begin
        ovf_set    = in_valid && fifo_full && !fifo_flush;
        ovf_clear  = wr_strobe && (address == ADDR_STATUS) && writedata[ST_OVF];
        ovf_d      = ovf_q;
        irq_mask_d = irq_mask_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
        if (wr_strobe && (address == ADDR_IRQ_MASK)) begin
            irq_mask_d = writedata[0];
        end
        irq_d = irq_mask_q && (!fifo_empty || ovf_q);
    end

    // Overflow, mask and interrupt flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q      <= 1'b0;
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ovf_q      <= ovf_d;
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    // Zero-wait-state read mux; DATA returns 0 when nothing is buffered.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = fifo_empty ? 32'd0 : 32'(fifo_head);
            ADDR_STATUS:   readdata = pack_status(!fifo_empty, fifo_full, ovf_q, level_byte);
            ADDR_IRQ_MASK: readdata = {31'd0, irq_mask_q};
            default:       readdata = '0;
        endcase
    end

endmodule
